// File: rtl/pfb_deadlock_aggregator_pkg.sv
// -----------------------------------------------------------------------------
// pfb_deadlock_pkg
// Shared definitions for the deadlock aggregator slice:
//   agg_state_t - aggregator FSM states (RUN, REPORT, HOLD)
//   clog2       - ceiling log2 for sizing counters and indices
//   width_of    - clog2 clamped to at least one bit, for index buses
// -----------------------------------------------------------------------------
package pfb_deadlock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPORT = 2'd1,
        HOLD   = 2'd2
    } agg_state_t;

    // Ceiling log2; clog2(1) is 0, so callers that need a real bus use width_of.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/pfb_deadlock_aggregator_if.sv
// -----------------------------------------------------------------------------
// pfb_deadlock_aggregator_if
// Report channel between the deadlock aggregator and the deadlock reporter.
//   report_valid - a blocked process index is presented
//   report_idx   - index of the presented blocked process
//   report_ready - consumer accepts report_idx
//   report_done  - one-cycle pulse after the last index is accepted
// The aggregator drives the master side, the reporter the slave side.
// -----------------------------------------------------------------------------
interface pfb_deadlock_aggregator_if #(
    parameter int IDX_W = 2
);

    logic             report_valid;
    logic [IDX_W-1:0] report_idx;
    logic             report_ready;
    logic             report_done;

    modport master (
        output report_valid,
        output report_idx,
        output report_done,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_idx,
        input  report_done,
        output report_ready
    );

endinterface

// File: rtl/pfb_deadlock_aggregator_lsb.sv
// -----------------------------------------------------------------------------
// pfb_lowest_set_idx
// Combinational priority encoder: returns the index of the lowest set bit of
// a mask and whether any bit is set at all.
//   mask_i - input bit mask
//   idx_o  - index of the lowest set bit (0 when the mask is empty)
//   any_o  - mask has at least one bit set
// -----------------------------------------------------------------------------
module pfb_lowest_set_idx #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        any_o = |mask_i;
    end

endmodule

// File: rtl/pfb_deadlock_aggregator.sv
// -----------------------------------------------------------------------------
// pfb_deadlock_aggregator
// Collects the per-process block/idle flags of the decimator's dataflow
// processes and declares a design-level deadlock once every non-idle process
// has been blocked for THRESHOLD consecutive cycles. The offending process
// set is then latched and its indices are handed out one at a time.
//   clock        - sole clock, rising edge
//   reset        - synchronous, active-low
//   block_in     - per-process block flags from the monitors
//   idle_in      - per-process idle flags
//   clear        - return to RUN and drop all latched state
//   deadlock     - sticky deadlock flag
//   blocked_mask - process set captured at detection
//   rpt          - report channel (valid/idx/ready/done), master side
// -----------------------------------------------------------------------------
module pfb_deadlock_aggregator
    import pfb_deadlock_pkg::*;
#(
    parameter int N_PROC    = 4,
    parameter int THRESHOLD = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_PROC-1:0]          block_in,
    input  logic [N_PROC-1:0]          idle_in,
    input  logic                       clear,
    output logic                       deadlock,
    output logic [N_PROC-1:0]          blocked_mask,
    pfb_deadlock_aggregator_if.master  rpt
);

    localparam int IDX_W = width_of(N_PROC);
    localparam int CNT_W = width_of(THRESHOLD + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(THRESHOLD - 1);
    localparam logic [N_PROC-1:0] ONE_HOT0 = N_PROC'(1);

    agg_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              deadlock_q, deadlock_d;
    logic [N_PROC-1:0] blockedMask_q, blockedMask_d;
    logic [N_PROC-1:0] work_q, work_d;
    logic              reportValid_q, reportValid_d;
    logic [IDX_W-1:0]  reportIdx_q, reportIdx_d;
    logic              reportDone_q, reportDone_d;

    logic [N_PROC-1:0] active;
    logic [N_PROC-1:0] blockActive;
    logic              cond;
    logic              handshake;
    logic [IDX_W-1:0]  nextIdx;
    logic              nextAny;

    // All-blocked condition; an all-idle design is never a deadlock.
    assign active      = ~idle_in;
    assign blockActive = block_in & active;
    assign cond        = (|active) && (blockActive == active);
    assign handshake   = reportValid_q && rpt.report_ready;

    // The index register is loaded from the next working mask, so the
    // presented index moves on the edge right after each handshake.
    pfb_lowest_set_idx #(
        .N     (N_PROC),
        .IDX_W (IDX_W)
    ) u_lowest_set_idx (
        .mask_i (work_d),
        .idx_o  (nextIdx),
        .any_o  (nextAny)
    );

    // Next-state logic. clear outranks both threshold detection and a
    // same-cycle handshake. cnt saturates at THRESHOLD-1 because reaching it
    // under cond leaves RUN.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        deadlock_d    = deadlock_q;
        blockedMask_d = blockedMask_q;
        work_d        = work_q;
        reportDone_d  = 1'b0;

        if (clear) begin
            state_d       = RUN;
            cnt_d         = '0;
            deadlock_d    = 1'b0;
            blockedMask_d = '0;
            work_d        = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cond) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d       = REPORT;
                            deadlock_d    = 1'b1;
                            blockedMask_d = blockActive;
                            work_d        = blockActive;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                REPORT: begin
                    if (handshake) begin
                        work_d = work_q & ~(ONE_HOT0 << reportIdx_q);
                        if (work_d == '0) begin
                            state_d      = HOLD;
                            reportDone_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        reportValid_d = (state_d == REPORT) && nextAny;
        reportIdx_d   = nextIdx;
    end

    // State and registered outputs; reset drops any in-flight index.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            deadlock_q    <= 1'b0;
            blockedMask_q <= '0;
            work_q        <= '0;
            reportValid_q <= 1'b0;
            reportIdx_q   <= '0;
            reportDone_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            deadlock_q    <= deadlock_d;
            blockedMask_q <= blockedMask_d;
            work_q        <= work_d;
            reportValid_q <= reportValid_d;
            reportIdx_q   <= reportIdx_d;
            reportDone_q  <= reportDone_d;
        end
    end

    assign deadlock         = deadlock_q;
    assign blocked_mask     = blockedMask_q;
    assign rpt.report_valid = reportValid_q;
    assign rpt.report_idx   = reportIdx_q;
    assign rpt.report_done  = reportDone_q;

endmodule

// File: tb/tb_pfb_deadlock_aggregator.sv
// -----------------------------------------------------------------------------
// tb_pfb_deadlock_aggregator
// Directed bench for pfb_deadlock_aggregator with N_PROC=4, THRESHOLD=16.
// A table of {inputs, cycles, expected outputs} records walks the main
// scenarios; hand-written sequences cover clear racing detection and a reset
// landing in the middle of a report.
// -----------------------------------------------------------------------------
module tb_pfb_deadlock_aggregator;

    localparam int N_PROC    = 4;
    localparam int THRESHOLD = 16;
    localparam int IDX_W     = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N_PROC-1:0] blockIn = '0;
    logic [N_PROC-1:0] idleIn  = '0;
    logic              clear   = 1'b0;
    logic              deadlock;
    logic [N_PROC-1:0] blockedMask;

    int checks   = 0;
    int failures = 0;

    pfb_deadlock_aggregator_if #(.IDX_W(IDX_W)) rptIf ();

    pfb_deadlock_aggregator #(
        .N_PROC    (N_PROC),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .block_in     (blockIn),
        .idle_in      (idleIn),
        .clear        (clear),
        .deadlock     (deadlock),
        .blocked_mask (blockedMask),
        .rpt          (rptIf.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [3:0]  blk;
        logic [3:0]  idl;
        logic        clr;
        logic        rdy;
        int          cycles;
        logic        expDl;
        logic [3:0]  expMask;
        logic        expValid;
        logic [1:0]  expIdx;
        logic        expDone;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [3:0] blk, input logic [3:0] idl,
                          input logic clr, input logic rdy, input int cycles,
                          input logic expDl, input logic [3:0] expMask, input logic expValid,
                          input logic [1:0] expIdx, input logic expDone);
        vec_t v;
        v.name = name; v.blk = blk; v.idl = idl; v.clr = clr; v.rdy = rdy;
        v.cycles = cycles; v.expDl = expDl; v.expMask = expMask;
        v.expValid = expValid; v.expIdx = expIdx; v.expDone = expDone;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives inputs, lets the given number of edges pass, then settles 1 ns.
    task automatic applyStimulus(input logic [3:0] blk, input logic [3:0] idl,
                                 input logic clr, input logic rdy, input int cycles);
        blockIn            = blk;
        idleIn             = idl;
        clear              = clr;
        rptIf.report_ready = rdy;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    // The index is only meaningful while a report is being presented.
    task automatic checkOutput(input string name, input logic expDl, input logic [3:0] expMask,
                               input logic expValid, input logic [1:0] expIdx, input logic expDone);
        compare({name, ".deadlock"}, {3'b0, deadlock}, {3'b0, expDl});
        compare({name, ".blocked_mask"}, blockedMask, expMask);
        compare({name, ".report_valid"}, {3'b0, rptIf.report_valid}, {3'b0, expValid});
        compare({name, ".report_done"}, {3'b0, rptIf.report_done}, {3'b0, expDone});
        if (expValid) begin
            compare({name, ".report_idx"}, {2'b0, rptIf.report_idx}, {2'b0, expIdx});
        end
    endtask

    initial begin
        rptIf.report_ready = 1'b0;

        // Two processes active, both blocked; drained with ready held high.
        addVec("s1_count15",    4'b0011, 4'b1100, 0, 1, 15, 0, 4'b0000, 0, 0, 0);
        addVec("s1_detect",     4'b0011, 4'b1100, 0, 1,  1, 1, 4'b0011, 1, 0, 0);
        addVec("s1_idx1",       4'b0011, 4'b1100, 0, 1,  1, 1, 4'b0011, 1, 1, 0);
        addVec("s1_done",       4'b0011, 4'b1100, 0, 1,  1, 1, 4'b0011, 0, 0, 1);
        addVec("s1_doneOnce",   4'b0011, 4'b1100, 0, 1,  1, 1, 4'b0011, 0, 0, 0);
        addVec("s1_holdIgnore", 4'b0000, 4'b1111, 0, 1,  5, 1, 4'b0011, 0, 0, 0);
        addVec("s1_clearHold",  4'b0000, 4'b1111, 1, 1,  1, 0, 4'b0000, 0, 0, 0);
        // Everything idle for 100 cycles is never a deadlock.
        for (int i = 0; i < 10; i++) begin
            addVec("s3_allIdle", 4'b0000, 4'b1111, 0, 1, 10, 0, 4'b0000, 0, 0, 0);
        end
        // One process unblocks in cycle 10; the count restarts on recovery.
        addVec("s2_pre",        4'b0011, 4'b1100, 0, 1,  9, 0, 4'b0000, 0, 0, 0);
        addVec("s2_drop",       4'b0001, 4'b1100, 0, 1,  1, 0, 4'b0000, 0, 0, 0);
        addVec("s2_recover15",  4'b0011, 4'b1100, 0, 1, 15, 0, 4'b0000, 0, 0, 0);
        addVec("s2_detect",     4'b0011, 4'b1100, 0, 1,  1, 1, 4'b0011, 1, 0, 0);
        addVec("s2_drain",      4'b0011, 4'b1100, 0, 1,  2, 1, 4'b0011, 0, 0, 1);
        addVec("s2_clear",      4'b0011, 4'b1100, 1, 1,  1, 0, 4'b0000, 0, 0, 0);
        // All four blocked, ready pattern 1,0,0,1,1,1.
        addVec("s4_count15",    4'b1111, 4'b0000, 0, 0, 15, 0, 4'b0000, 0, 0, 0);
        addVec("s4_detect",     4'b1111, 4'b0000, 0, 0,  1, 1, 4'b1111, 1, 0, 0);
        addVec("s4_r1",         4'b1111, 4'b0000, 0, 1,  1, 1, 4'b1111, 1, 1, 0);
        addVec("s4_r0a",        4'b1111, 4'b0000, 0, 0,  1, 1, 4'b1111, 1, 1, 0);
        addVec("s4_r0b",        4'b1111, 4'b0000, 0, 0,  1, 1, 4'b1111, 1, 1, 0);
        addVec("s4_r1a",        4'b1111, 4'b0000, 0, 1,  1, 1, 4'b1111, 1, 2, 0);
        addVec("s4_r1b",        4'b1111, 4'b0000, 0, 1,  1, 1, 4'b1111, 1, 3, 0);
        addVec("s4_r1c",        4'b1111, 4'b0000, 0, 1,  1, 1, 4'b1111, 0, 0, 1);
        addVec("s4_after",      4'b1111, 4'b0000, 0, 1,  1, 1, 4'b1111, 0, 0, 0);
        addVec("s4_clear",      4'b1111, 4'b0000, 1, 0,  1, 0, 4'b0000, 0, 0, 0);

        // Reset state.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset", 0, 4'b0000, 0, 0, 0);
        compare("reset.report_idx", {2'b0, rptIf.report_idx}, 4'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].blk, vecs[i].idl, vecs[i].clr, vecs[i].rdy, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].expDl, vecs[i].expMask,
                        vecs[i].expValid, vecs[i].expIdx, vecs[i].expDone);
        end

        // clear lands on the 16th cond cycle: no detection, count restarts.
        applyStimulus(4'b0011, 4'b1100, 0, 0, 15);
        checkOutput("clr16_pre", 0, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0011, 4'b1100, 1, 0, 1);
        checkOutput("clr16_edge", 0, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0011, 4'b1100, 0, 0, 15);
        checkOutput("clr16_restart15", 0, 4'b0000, 0, 0, 0);
        applyStimulus(4'b0011, 4'b1100, 0, 0, 1);
        checkOutput("clr16_restart16", 1, 4'b0011, 1, 0, 0);
        // clear wins over a same-cycle handshake.
        applyStimulus(4'b0011, 4'b1100, 1, 1, 1);
        checkOutput("clrHandshake", 0, 4'b0000, 0, 0, 0);

        // Reset while index 2 is pending.
        applyStimulus(4'b1111, 4'b0000, 0, 0, 16);
        checkOutput("rstMid_detect", 1, 4'b1111, 1, 0, 0);
        applyStimulus(4'b1111, 4'b0000, 0, 1, 2);
        checkOutput("rstMid_idx2", 1, 4'b1111, 1, 2, 0);
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 0, 1, 1);
        checkOutput("rstMid_reset", 0, 4'b0000, 0, 0, 0);
        compare("rstMid_reset.report_idx", {2'b0, rptIf.report_idx}, 4'h0);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(4'b0000, 4'b1111, 0, 1, 1);
            checkOutput("rstMid_quiet", 0, 4'b0000, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/pfb_deadlock_aggregator.md
# pfb_deadlock_aggregator

Aggregates the per-process `block` flags produced by the per-process deadlock monitors of `pfb_multichannel_decimator` (one monitor per dataflow process, e.g. `read_inputs_U0`), together with each process's idle flag. It declares a design-level deadlock only after all non-idle processes have been blocked for a programmable number of consecutive cycles. It then latches the offending process set and reports the blocked process indices one at a time over a valid/ready port. The block sits directly downstream of the monitors in the simulation harness and feeds the testbench's deadlock reporter.

## Interface
- `N_PROC`, 4: number of monitored dataflow processes (≥1).
- `THRESHOLD`, 16: consecutive all-blocked cycles required to declare deadlock (≥1).
- `IDX_W`, `max(1, clog2(N_PROC))`: derived; width of `report_idx`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset); one clock, no asynchronous path.
- `block_in`  in  N_PROC  bit i = `block` output of monitor i.
- `idle_in`  in  N_PROC  bit i = process i idle.
- `clear`  in  1  single-cycle request to return to RUN and drop all latched state.
- `deadlock`  out  1  sticky deadlock flag.
- `blocked_mask`  out  N_PROC  process set captured at detection.
- `report_valid`  out  1  a blocked index is presented.
- `report_idx`  out  IDX_W  index of the presented blocked process.
- `report_ready`  in  1  consumer accepts `report_idx`.
- `report_done`  out  1  one-cycle pulse after the last index is accepted.

## Operation
- Per-cycle condition: `cond = (|active) && ((block_in & active) == active)`, where `active = ~idle_in`.
- The condition is false when every process is idle.
- States: RUN, REPORT, HOLD.
- RUN:
  - Counter `cnt` (width `clog2(THRESHOLD+1)`) increments while `cond`.
  - Any cycle with `!cond` clears `cnt` to 0.
  - If `cond` holds and `cnt == THRESHOLD-1`, transition to REPORT on the next edge: set `deadlock`, capture `blocked_mask <= block_in & active`, and load the working mask with the same value.
- REPORT:
  - `report_valid` = 1.
  - `report_idx` = lowest set bit of the working mask.
  - On `report_valid && report_ready`, clear that bit.
  - If the cleared bit was the last one, go to HOLD and pulse `report_done` for exactly the following cycle.
  - `report_idx` is held stable while `report_valid && !report_ready`.
- HOLD:
  - `deadlock` and `blocked_mask` are held.
  - `block_in`/`idle_in` are ignored.
  - The block leaves HOLD only on `clear`.
- `clear`, in any state:
  - Next state RUN; `cnt`, `deadlock`, `blocked_mask`, the working mask, `report_valid` and `report_done` all go to 0.
  - `clear` has priority over threshold detection and over a same-cycle handshake.
- `blocked_mask` is non-empty by construction; REPORT always emits at least one index.

## Timing
- Reset values: `deadlock`=0, `blocked_mask`=0, `report_valid`=0, `report_idx`=0, `report_done`=0, state=RUN, `cnt`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Detection latency: if `cond` first holds in cycle k and stays true, `deadlock` rises at the edge ending cycle k+THRESHOLD-1 (visible in cycle k+THRESHOLD).
- `report_valid` rises in the same cycle as `deadlock`.
- With THRESHOLD=1, a single `cond` cycle is sufficient.
- Report throughput: one index per cycle when `report_ready` is held high.
- `report_idx` updates on the edge after each handshake.
- `report_done` asserts in the cycle after the last handshake.
- Reset asserted mid-REPORT: all state returns to reset values at that edge; an in-flight index is dropped.
- `cnt` saturates at THRESHOLD-1 and never wraps.

## Structure
- Shared package `pfb_deadlock_pkg` holds:
  - the state enum `agg_state_t` {RUN, REPORT, HOLD};
  - the `clog2`-based width helper used for `IDX_W` and `cnt`.
- One sub-module, `pfb_lowest_set_idx`: a combinational priority encoder (N-bit mask → index of lowest set bit, plus `any` flag).
- The sub-module is reused wherever the team needs lowest-set-bit selection.

## Test plan
All scenarios use N_PROC=4, THRESHOLD=16.
- Active set 4'b0011 (`idle_in`=4'b1100), `block_in`=4'b0011 held for 16 cycles → `deadlock`=1 on cycle 16, `blocked_mask`=4'b0011; indices 0 then 1 with `report_ready`=1; `report_done` pulses once.
- Same as the previous scenario but `block_in[1]` drops to 0 in cycle 10, then all blocked again → `cnt` restarts; `deadlock` rises 16 cycles after the recovery, not before.
- `idle_in`=4'b1111 and `block_in`=4'b0000 for 100 cycles → `deadlock` stays 0 and `report_valid` stays 0.
- All four processes blocked, `report_ready` toggling 1,0,0,1,1,1 → indices 0,1,2,3 emitted in order; `report_idx` stable while stalled; `report_done` appears after index 3.
- `clear` asserted in the same cycle as the 16th `cond` cycle → no deadlock; state RUN with `cnt`=0. `clear` in HOLD → `deadlock` and `blocked_mask` return to 0 on the next cycle.
- `reset`=0 for one cycle while in REPORT with index 2 pending → all outputs return to reset values on the next cycle; no further indices are emitted.
